// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between the MEM/WB stage (master) and data memory (slave).
interface mem_wb_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // Handshake: mem_req rises with we/addr/wdata valid and holds them stable until
  // the first rising edge that sees mem_ack high; mem_ack with mem_req low is ignored.
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory-access/writeback stage: issues one load/store at a time over the req/ack bus,
// stalls upstream while it is outstanding, and pulses a register-file writeback.
module mem_wb_stage #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int REG_AW  = 3,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   ex_alu,
  input  logic                ex_wreg,
  input  logic [REG_AW-1:0]   ex_rd,
  input  logic [ADDR_W-1:0]   ex_addr,
  input  logic [DATA_W-1:0]   ex_sdata,
  input  logic                ex_we,
  input  logic                ex_re,
  output logic                stall,
  mem_wb_stage_if.master      mem,
  output logic                wb_en,
  output logic [REG_AW-1:0]   wb_addr,
  output logic [DATA_W-1:0]   wb_data,
  output logic                mem_err,
  output logic [0:0]          dbg_state
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wb_en_q, wb_en_d;
  logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              err_q, err_d;
  logic [REG_AW-1:0] lat_rd_q, lat_rd_d;
  logic              lat_wreg_q, lat_wreg_d;
  logic [DATA_W-1:0] lat_alu_q, lat_alu_d;
  logic              lat_read_q, lat_read_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wb_en_d    = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    err_d      = err_q;
    lat_rd_d   = lat_rd_q;
    lat_wreg_d = lat_wreg_q;
    lat_alu_d  = lat_alu_q;
    lat_read_d = lat_read_q;
    case (state_q)
      S_IDLE: begin
        if (ex_re ^ ex_we) begin
          req_d      = 1'b1;
          we_d       = ex_we;
          addr_d     = ex_addr;
          wdata_d    = ex_sdata;
          lat_rd_d   = ex_rd;
          lat_wreg_d = ex_wreg;
          lat_alu_d  = ex_alu;
          lat_read_d = ex_re;
          cnt_d      = CNT_W'(1);
          state_d    = S_WAIT;
        end else begin
          // Both enables set is illegal: flag it, skip memory, keep the ALU writeback.
          if (ex_re && ex_we) err_d = 1'b1;
          wb_en_d   = ex_wreg;
          wb_addr_d = ex_rd;
          wb_data_d = ex_alu;
        end
      end
      S_WAIT: begin
        // Ack is tested first so it beats a timeout landing on the same edge.
        if (mem.mem_ack) begin
          req_d     = 1'b0;
          wb_en_d   = lat_wreg_q;
          wb_addr_d = lat_rd_q;
          wb_data_d = lat_read_q ? mem.mem_rdata : lat_alu_q;
          state_d   = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wb_en_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
      lat_rd_q   <= '0;
      lat_wreg_q <= 1'b0;
      lat_alu_q  <= '0;
      lat_read_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wb_en_q    <= wb_en_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
      lat_rd_q   <= lat_rd_d;
      lat_wreg_q <= lat_wreg_d;
      lat_alu_q  <= lat_alu_d;
      lat_read_q <= lat_read_d;
    end
  end

  assign stall         = (state_q == S_WAIT);
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign wb_en         = wb_en_q;
  assign wb_addr       = wb_addr_q;
  assign wb_data       = wb_data_q;
  assign mem_err       = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: driver tasks feed instructions, a memory responder acks with
// programmable latency, and a scoreboard matches writeback pulses against expected ones.
module tb_mem_wb_stage;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int RW = 3;
  localparam int QW = RW + DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] ex_alu = '0;
  logic          ex_wreg = 1'b0;
  logic [RW-1:0] ex_rd = '0;
  logic [AW-1:0] ex_addr = '0;
  logic [DW-1:0] ex_sdata = '0;
  logic          ex_we = 1'b0;
  logic          ex_re = 1'b0;
  logic          stall, wb_en, mem_err;
  logic [RW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [0:0]    dbg_state;

  mem_wb_stage_if #(.DATA_W(DW), .ADDR_W(AW)) m_if ();

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_alu(ex_alu), .ex_wreg(ex_wreg), .ex_rd(ex_rd), .ex_addr(ex_addr),
    .ex_sdata(ex_sdata), .ex_we(ex_we), .ex_re(ex_re),
    .stall(stall), .mem(m_if.master),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .mem_err(mem_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int            ack_at = 0;      // req cycle on which ack is raised; 0 = never
  logic [DW-1:0] rd_val = '0;
  logic [AW-1:0] exp_addr = '0;
  logic          exp_we = 1'b0;
  logic [DW-1:0] exp_wdata = '0;
  logic          late_ack = 1'b0;
  int            req_cyc = 0;
  int            last_req_len = 0;
  int            req_count = 0;

  initial begin
    m_if.mem_ack   = 1'b0;
    m_if.mem_rdata = '0;
  end

  always @(negedge clk) begin
    if (m_if.mem_req) begin
      req_cyc++;
      check("mem_addr", m_if.mem_addr, exp_addr);
      check("mem_we", m_if.mem_we, exp_we);
      if (exp_we) check("mem_wdata", m_if.mem_wdata, exp_wdata);
      m_if.mem_ack   = (ack_at != 0) && (req_cyc == ack_at);
      m_if.mem_rdata = m_if.mem_ack ? rd_val : $urandom_range(0, 16'hFFFF);
    end else begin
      if (req_cyc > 0) begin
        last_req_len = req_cyc;
        req_count++;
      end
      req_cyc        = 0;
      m_if.mem_ack   = late_ack;
      m_if.mem_rdata = $urandom_range(0, 16'hFFFF);
    end
  end

  // ---------------- scoreboard ----------------
  logic [QW-1:0] exp_q[$];

  always @(negedge clk) begin
    logic [QW-1:0] e;
    check("stall_vs_req", stall, m_if.mem_req);
    if (wb_en) begin
      if (exp_q.size() == 0) begin
        check("wb_spurious", {wb_addr, wb_data}, '0);
      end else begin
        e = exp_q.pop_front();
        check("wb_addr", wb_addr, e[QW-1:DW]);
        check("wb_data", wb_data, e[DW-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bubble();
    ex_re = 1'b0; ex_we = 1'b0; ex_wreg = 1'b0;
    ex_rd = '0; ex_alu = '0; ex_addr = '0; ex_sdata = '0;
  endtask

  // Present one instruction and hold it until the stage consumes it.
  task automatic drive(input logic re, input logic we, input logic wreg, input logic [RW-1:0] rd,
                       input logic [DW-1:0] alu, input logic [AW-1:0] addr, input logic [DW-1:0] sdata);
    int   n = 0;
    logic s;
    ex_re = re; ex_we = we; ex_wreg = wreg; ex_rd = rd;
    ex_alu = alu; ex_addr = addr; ex_sdata = sdata;
    do begin
      @(negedge clk); s = stall;
      @(posedge clk); n++;
    end while (s && n < 40);
    if (s) check("drive_timeout", 1, 0);
    #1;
    bubble();
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int rc;
    bubble();
    #2;
    check("rst_stall", stall, 0);
    check("rst_req", m_if.mem_req, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_err", mem_err, 0);
    do_reset();
    check("rst_state", dbg_state, 0);

    // 1: ALU passthrough
    exp_q.push_back({3'd5, 16'h1234});
    drive(0, 0, 1, 3'd5, 16'h1234, 16'h0, 16'h0);
    idle(2);

    // 2: load acked on third request cycle, then a held ALU instruction
    ack_at = 3; rd_val = 16'hBEEF; exp_addr = 16'h0040; exp_we = 1'b0;
    exp_q.push_back({3'd2, 16'hBEEF});
    drive(1, 0, 1, 3'd2, 16'h9999, 16'h0040, 16'h0);
    exp_q.push_back({3'd3, 16'h0007});
    drive(0, 0, 1, 3'd3, 16'h0007, 16'h0, 16'h0);
    idle(3);
    check("load_req_len", last_req_len, 3);

    // 3: store acked in the first request cycle, no writeback
    ack_at = 1; exp_addr = 16'h0100; exp_we = 1'b1; exp_wdata = 16'hA5A5;
    drive(0, 1, 0, 3'd4, 16'h0, 16'h0100, 16'hA5A5);
    idle(3);
    check("store_req_len", last_req_len, 1);
    check("store_err", mem_err, 0);

    // 4a: read that is never acked times out
    ack_at = 0; exp_addr = 16'h0222; exp_we = 1'b0;
    drive(1, 0, 1, 3'd4, 16'h0, 16'h0222, 16'h0);
    idle(20);
    check("tmo_req_len", last_req_len, 15);
    check("tmo_err", mem_err, 1);
    check("tmo_state", dbg_state, 0);
    exp_q.push_back({3'd7, 16'h0077});
    drive(0, 0, 1, 3'd7, 16'h0077, 16'h0, 16'h0);
    idle(2);

    // 4b: ack exactly on the timeout cycle still completes
    do_reset();
    check("tmo_clr_err", mem_err, 0);
    ack_at = 15; rd_val = 16'h1111; exp_addr = 16'h0333;
    exp_q.push_back({3'd6, 16'h1111});
    drive(1, 0, 1, 3'd6, 16'h0, 16'h0333, 16'h0);
    idle(18);
    check("edge_req_len", last_req_len, 15);
    check("edge_err", mem_err, 0);

    // 5: illegal op with both enables set
    rc = req_count;
    exp_q.push_back({3'd1, 16'h00FF});
    drive(1, 1, 1, 3'd1, 16'h00FF, 16'h0444, 16'h0);
    idle(3);
    check("illegal_err", mem_err, 1);
    check("illegal_no_req", req_count, rc);

    // 6: reset on second request cycle abandons the access
    do_reset();
    ack_at = 0; exp_addr = 16'h0555;
    drive(1, 0, 1, 3'd5, 16'h0, 16'h0555, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_req", m_if.mem_req, 0);
    check("arst_stall", stall, 0);
    check("arst_wb_en", wb_en, 0);
    check("arst_err", mem_err, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    late_ack = 1'b1;
    rc = req_count;
    exp_q.push_back({3'd6, 16'hCAFE});
    drive(0, 0, 1, 3'd6, 16'hCAFE, 16'h0, 16'h0);
    idle(3);
    late_ack = 1'b0;
    idle(2);
    check("late_ack_no_req", req_count, rc);
    check("late_ack_err", mem_err, 0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
